// File: rtl/stepper_drive_pio_pkg.sv
// Shared constants for the stepper coil driver: register addresses, CTRL bit
// positions, the 8-entry coil phase table and the minimum step period.
// No ports; imported by the interface user modules.
package stepper_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STEPS  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_W      = 6;
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_HALF   = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_CONT   = 4;
  localparam int CTRL_HOLD   = 5;

  // Coil pattern {D,C,B,A}; element 0 is the rightmost entry.
  // Odd indices are the two-coil patterns used by full stepping.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/stepper_drive_pio_if.sv
// Avalon-MM slave bus bundle for the stepper coil driver.
//   address/chipselect/write_n/writedata : master -> slave
//   readdata (registered, 1-cycle latency), irq : slave -> master
interface stepper_drive_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/stepper_drive_pio_phase_seq.sv
// Coil phase sequencer: holds the 3-bit phase index and advances it on tick.
//   clk, reset : system clock, synchronous active-high reset (index -> 1)
//   tick       : advance one step this cycle
//   dir        : 1 = forward (increasing index)
//   half_step  : 1 = move by 1, 0 = move by 2 and land on an odd index
//   phase      : coil pattern for the index that will be current after this edge
module stepper_phase_seq
  import stepper_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       dir,
  input  logic       half_step,
  output logic [3:0] phase
);

  logic [2:0] phase_idx;
  logic [2:0] idx_next;
  logic [2:0] full_idx;

  always_comb begin
    idx_next = phase_idx;
    full_idx = dir ? (phase_idx + 3'd2) : (phase_idx - 3'd2);
    if (tick) begin
      if (half_step) begin
        idx_next = dir ? (phase_idx + 3'd1) : (phase_idx - 3'd1);
      end else begin
        idx_next = full_idx | 3'b001;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_idx <= 3'd1;
    end else begin
      phase_idx <= idx_next;
    end
  end

  // Look-ahead lookup lets the registered coil output update on the same edge
  // as the index, one clock after tick.
  assign phase = PHASE_TABLE[idx_next];

endmodule

// File: rtl/stepper_drive_pio.sv
// Stepper motor coil driver on the Avalon-MM data bus.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave port (address, chipselect, write_n, writedata,
//                readdata, irq); irq = done & irq_en
//   coil_out   : registered coil drive {D,C,B,A}
module stepper_drive_pio
  import stepper_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  stepper_drive_pio_if.slave  bus,
  output logic [3:0]          coil_out
);

  logic [CTRL_W-1:0]   ctrl;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] eff_period;
  logic [PERIOD_W-1:0] prescaler;
  logic [COUNT_W-1:0]  remaining;
  logic                done;
  logic                wr, wr_ctrl, wr_period, wr_steps, wr_status;
  logic                busy, tick, last_step;
  logic [3:0]          phase;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_ctrl   = wr & (bus.address == ADDR_CTRL);
  assign wr_period = wr & (bus.address == ADDR_PERIOD);
  assign wr_steps  = wr & (bus.address == ADDR_STEPS);
  assign wr_status = wr & (bus.address == ADDR_STATUS);

  assign eff_period = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
  assign busy       = ctrl[CTRL_ENABLE] & (ctrl[CTRL_CONT] | (remaining != '0));
  // >= so that shrinking PERIOD below the running count steps on the next clock
  assign tick       = busy & (prescaler >= (eff_period - PERIOD_W'(1)));
  // A STEPS write in the same cycle replaces the decrement, so no 1->0 transition
  assign last_step  = tick & ~ctrl[CTRL_CONT] & (remaining == COUNT_W'(1)) & ~wr_steps;

  stepper_phase_seq u_phase_seq (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .dir       (ctrl[CTRL_DIR]),
    .half_step (ctrl[CTRL_HALF]),
    .phase     (phase)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl         <= '0;
      period       <= '0;
      remaining    <= '0;
      done         <= 1'b0;
      prescaler    <= '0;
      coil_out     <= 4'b0000;
      bus.readdata <= '0;
    end else begin
      if (wr_ctrl)   ctrl   <= bus.writedata[CTRL_W-1:0];
      if (wr_period) period <= bus.writedata[PERIOD_W-1:0];

      if (wr_steps) begin
        remaining <= bus.writedata[COUNT_W-1:0];
      end else if (tick && !ctrl[CTRL_CONT]) begin
        remaining <= remaining - COUNT_W'(1);
      end

      if (last_step) begin
        done <= 1'b1;
      end else if (wr_status) begin
        done <= 1'b0;
      end

      if (!busy || wr_steps || tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PERIOD_W'(1);
      end

      coil_out <= (ctrl[CTRL_ENABLE] | ctrl[CTRL_HOLD]) ? phase : 4'b0000;

      case (bus.address)
        ADDR_CTRL:   bus.readdata <= 32'(ctrl);
        ADDR_PERIOD: bus.readdata <= 32'(period);
        ADDR_STEPS:  bus.readdata <= 32'(remaining);
        default:     bus.readdata <= {30'd0, done, busy};
      endcase
    end
  end

  assign bus.irq = done & ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_stepper_drive_pio.sv
module tb_stepper_drive_pio;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] coil_out;

  stepper_drive_pio_if bus ();

  stepper_drive_pio #(.PERIOD_W(24), .COUNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .coil_out (coil_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Coil patterns written out independently of the design package.
  logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                          4'b0100, 4'b1100, 4'b1000, 4'b1001};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_next(input int idx, input bit dir, input bit half);
    int n;
    n = dir ? idx + (half ? 1 : 2) : idx - (half ? 1 : 2);
    n = ((n % 8) + 8) % 8;
    if (!half) n = n | 1;
    return n;
  endfunction

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address = addr; bus.writedata = data;
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.address = addr;
    @(negedge clk);
    data = bus.readdata;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Coil must hold 'prev' until eff clocks elapse, then show 'nxt'.
  task automatic expect_step(input string tag, input int eff,
                             input logic [3:0] prev, input logic [3:0] nxt);
    repeat (eff - 1) @(negedge clk);
    check({tag, "_hold"}, 32'(coil_out), 32'(prev));
    @(negedge clk);
    check(tag, 32'(coil_out), 32'(nxt));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [3:0]  hrev [9] = '{4'b0001, 4'b1001, 4'b1000, 4'b1100, 4'b0100,
                              4'b0110, 4'b0010, 4'b0011, 4'b0001};
    int idx, p, n, eff;
    bit dir, half;

    reset = 1'b1;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset values
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      check($sformatf("reset_rd%0d", a), rd, 32'd0);
    end
    check("reset_coil", 32'(coil_out), 32'd0);
    check("reset_irq", 32'(bus.irq), 32'd0);
    bus_write(2'd0, 32'h20);
    @(negedge clk);
    check("hold_only_coil", 32'(coil_out), 32'b0011);

    // Full step forward, 3 steps, irq
    do_reset();
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'h0B);
    expect_step("full1", 4, 4'b0011, 4'b0110);
    expect_step("full2", 4, 4'b0110, 4'b1100);
    repeat (3) @(negedge clk);
    check("full3_hold", 32'(coil_out), 32'b1100);
    check("irq_before_done", 32'(bus.irq), 32'd0);
    @(negedge clk);
    check("full3", 32'(coil_out), 32'b1001);
    check("irq_on_done", 32'(bus.irq), 32'd1);
    bus_read(2'd3, rd);
    check("full_status", rd, 32'd2);
    bus_read(2'd2, rd);
    check("full_remaining", rd, 32'd0);
    bus_write(2'd3, 32'd0);
    check("irq_cleared", 32'(bus.irq), 32'd0);

    // Half step reverse, 9 steps with wrap
    do_reset();
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'd9);
    bus_write(2'd0, 32'h05);
    for (int k = 0; k < 9; k++)
      expect_step($sformatf("hrev%0d", k), 2, (k == 0) ? 4'b0011 : hrev[k-1], hrev[k]);
    bus_read(2'd3, rd);
    check("hrev_status", rd, 32'd2);
    check("hrev_irq_masked", 32'(bus.irq), 32'd0);

    // Period clamp and continuous mode with STEPS=0
    for (int pv = 0; pv < 2; pv++) begin
      do_reset();
      bus_write(2'd1, 32'(pv));
      bus_write(2'd0, 32'h17);
      idx = 1;
      for (int k = 0; k < 6; k++) begin
        n = model_next(idx, 1'b1, 1'b1);
        expect_step($sformatf("clamp%0d_%0d", pv, k), 2, tbl[idx], tbl[n]);
        idx = n;
      end
      bus_read(2'd2, rd);
      check("cont_remaining", rd, 32'd0);
      bus_read(2'd3, rd);
      check("cont_status", rd, 32'd1);
    end

    // STEPS write coinciding with a tick
    do_reset();
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'd10);
    bus_write(2'd0, 32'h03);
    repeat (2) @(negedge clk);
    bus_write(2'd2, 32'd5);
    check("steps_tick_phase", 32'(coil_out), 32'b0110);
    bus_read(2'd2, rd);
    check("steps_tick_remaining", rd, 32'd5);

    // STATUS write coinciding with the final tick
    do_reset();
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h0B);
    repeat (2) @(negedge clk);
    bus_write(2'd3, 32'd0);
    check("status_tick_irq", 32'(bus.irq), 32'd1);
    bus_read(2'd3, rd);
    check("status_tick_done", rd, 32'd2);

    // Disable mid-move, then resume
    do_reset();
    bus_write(2'd1, 32'd3);
    bus_write(2'd2, 32'd5);
    bus_write(2'd0, 32'h03);
    expect_step("mid1", 3, 4'b0011, 4'b0110);
    expect_step("mid2", 3, 4'b0110, 4'b1100);
    bus_write(2'd0, 32'h00);
    @(negedge clk);
    check("mid_off_coil", 32'(coil_out), 32'd0);
    bus_read(2'd2, rd);
    check("mid_frozen1", rd, 32'd3);
    repeat (5) @(negedge clk);
    bus_read(2'd2, rd);
    check("mid_frozen2", rd, 32'd3);
    bus_write(2'd0, 32'h03);
    expect_step("mid_resume", 3, 4'b1100, 4'b1001);

    // Reset mid-move
    do_reset();
    check("rst_mid_coil", 32'(coil_out), 32'd0);
    check("rst_mid_irq", 32'(bus.irq), 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      check($sformatf("rst_mid_rd%0d", a), rd, 32'd0);
    end
    bus_write(2'd0, 32'h20);
    @(negedge clk);
    check("rst_mid_idx", 32'(coil_out), 32'b0011);

    // Randomized moves against the reference model
    for (int it = 0; it < 6; it++) begin
      do_reset();
      p    = $urandom_range(0, 5);
      n    = $urandom_range(1, 5);
      dir  = 1'($urandom_range(0, 1));
      half = 1'($urandom_range(0, 1));
      eff  = (p < 2) ? 2 : p;
      bus_write(2'd1, 32'(p));
      bus_write(2'd2, 32'(n));
      bus_write(2'd0, 32'h09 | (32'(dir) << 1) | (32'(half) << 2));
      idx = 1;
      for (int k = 0; k < n; k++) begin
        int nx;
        nx = model_next(idx, dir, half);
        if (k == n - 1) begin
          repeat (eff - 1) @(negedge clk);
          check($sformatf("rnd%0d_irq_pre", it), 32'(bus.irq), 32'd0);
          @(negedge clk);
          check($sformatf("rnd%0d_last", it), 32'(coil_out), 32'(tbl[nx]));
          check($sformatf("rnd%0d_irq", it), 32'(bus.irq), 32'd1);
        end else begin
          expect_step($sformatf("rnd%0d_s%0d", it, k), eff, tbl[idx], tbl[nx]);
        end
        idx = nx;
      end
      bus_read(2'd3, rd);
      check($sformatf("rnd%0d_status", it), rd, 32'd2);
      bus_read(2'd2, rd);
      check($sformatf("rnd%0d_remaining", it), rd, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_drive_pio.md
Name: stepper_drive_pio

Overview:
Avalon-MM slave that drives the four coil lines of a unipolar/bipolar stepper motor from a programmable step sequencer. It is the output-side counterpart of the board's input PIO: software writes the direction, step mode, step period and step count, and the block generates the timed coil phase sequence. It raises irq when a commanded move completes. Sits on the Nios II data bus next to the input PIO; coil_out goes to the motor driver pins.

Parameters:
PERIOD_W, 24, width of the step-period register (clocks per step)
COUNT_W, 16, width of the step-count register

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe (valid with chipselect)
writedata  in  32  write data
readdata  out  32  registered read data, 1-cycle latency, unused bits 0
irq  out  1  done & irq_en
coil_out  out  4  registered coil drive {D,C,B,A}

Behaviour:
- Reset: one clock, synchronous, active-high. All registers are 0 except phase_idx=1. The outputs are readdata=0, irq=0 and coil_out=0000.
- Register map (wr = chipselect & ~write_n):
  - addr0 CTRL R/W: b0 enable, b1 dir (1=forward), b2 half_step, b3 irq_en, b4 continuous, b5 hold; other bits read 0.
  - addr1 PERIOD R/W [PERIOD_W-1:0]. The effective period is max(PERIOD,2).
  - addr2 STEPS. A write loads remaining and clears the prescaler. A read returns remaining.
  - addr3 STATUS. Read returns b0 busy, b1 done. Any write clears done.
- readdata is updated every clock from the address mux, regardless of chipselect, exactly like the input PIO.
- busy = enable & (continuous | remaining!=0).
- Prescaler: counts 0..eff_period-1 while busy and holds 0 otherwise. tick is asserted when prescaler==eff_period-1 and busy.
- On tick:
  - phase_idx (3-bit) advances. Half step moves by ±1. Full step moves by ±2 with bit0 then forced to 1. Both wrap modulo 8.
  - If not continuous, remaining decrements. When it goes 1->0, done is set in the same cycle.
- Phase table, idx0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. Full step therefore uses only 0011, 0110, 1100, 1001.
- coil_out (registered) is table[phase_idx] when enable or hold is set, and 0000 otherwise.
  - First step output appears eff_period clocks after busy rises.
  - coil_out changes 1 clock after tick.
- Simultaneous events:
  - STEPS write and tick in the same cycle: the write wins; remaining is loaded and the decrement is dropped, while phase_idx still advances.
  - done set and STATUS write in the same cycle: set wins.
  - Clearing enable mid-move freezes phase_idx and remaining; setting it again resumes with the prescaler starting from 0.
  - Writing STEPS=0 while not continuous stops the move without setting done.
  - A PERIOD change takes effect at the next prescaler wrap, because the compare uses the live register. If the prescaler is already ≥ the new eff_period-1, it runs until its own width wraps. Implementation must instead compare with ≥ so the step occurs on the next clock.
  - A direction change takes effect on the next tick.
- irq = done & irq_en (combinational from registers).

Decomposition:
- Shared package stepper_pkg holds:
  - register address constants ADDR_CTRL/PERIOD/STEPS/STATUS;
  - CTRL bit positions;
  - the 8-entry PHASE_TABLE constant;
  - the MIN_PERIOD=2 constant.
- One natural sub-module, stepper_phase_seq: phase_idx register plus next-index arithmetic and table lookup. Inputs are tick, dir and half_step; output is the 4-bit phase.
- The bus register file, prescaler and step counter stay in the top level.

Test Plan:
- Reset, then read addr0..3 → readdata 0 each (1-cycle latency); coil_out=0000; irq=0. Set hold only → coil_out=0011.
- PERIOD=4, STEPS=3, CTRL=0b001011 (enable, fwd, full, irq_en):
  - coil_out is 0011, then 0110 / 1100 / 1001 at 4-clock intervals;
  - done=1 and irq=1 on the third tick;
  - busy=0 and remaining=0 afterwards;
  - a STATUS write clears irq.
- Half step reverse (CTRL=0b000101), PERIOD=2, STEPS=9 from idx1 → coils 0001, 1001, 1000, 1100, 0100, 0110, 0010, 0011, 0001 (wrap verified), with ticks every 2 clocks.
- PERIOD=0 and PERIOD=1 → steps every 2 clocks (clamp). Continuous mode with STEPS=0 runs indefinitely with remaining=0 and done never set.
- Same-cycle cases:
  - STEPS=5 write coinciding with a tick → remaining reads 5;
  - STATUS write coinciding with the final tick → done reads 1.
- Mid-move:
  - clear enable after 2 steps, hold=0 → coil_out=0000 and remaining is frozen; re-enable → motion resumes from the frozen idx after a full period.
  - assert reset mid-move → all state returns to reset values on the next clock.
